// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: default geometry and small bit-vector helpers.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fifo_pkg;

  // Default geometry shared with the FIFO top.
  localparam int FIFO_ADDR_W = 3;
  localparam int FIFO_DEPTH  = 8;

  // Reflected binary-to-Gray conversion; callers cast down to their width.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // True when the vector is all zero or has exactly one bit set.
  function automatic logic is_onehot0(input logic [63:0] v);
    return (v & (v - 64'd1)) == 64'd0;
  endfunction

endpackage

// File: rtl/onehot_dec.sv
// Pointer-to-row decoder: drives a one-hot enable from an address, or zero when disabled.
// Latency: purely combinational, zero cycles.
// Backpressure: none; addresses at or beyond DEPTH decode to all zero.
module onehot_dec #(
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 8
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic              en,
  output logic [DEPTH-1:0]  onehot
);

  // One comparator per row; rows beyond the reachable range never match.
  for (genvar i = 0; i < DEPTH; i++) begin : g_row
    assign onehot[i] = en && (addr == ADDR_W'(i));
  end

endmodule

// File: rtl/fifo_wr_sel.sv
// Wrapping FIFO pointer with registered one-hot row select, lap bit and load-range error.
// Latency: one clock from load/advance/en to ptr, wrap, sel, load_err (and ptr_gray).
// Backpressure: none; load beats advance, out-of-range loads are rejected with a pulse.
// Optional macro FIFO_WR_SEL_GRAY_EN adds the registered Gray lap-extended pointer ptr_gray.
module fifo_wr_sel
  import fifo_pkg::*;
#(
  parameter int ADDR_W = FIFO_ADDR_W,
  parameter int DEPTH  = FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              advance,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  output logic [DEPTH-1:0]  sel,
  output logic [ADDR_W-1:0] ptr,
  output logic              wrap,
  output logic              load_err
`ifdef FIFO_WR_SEL_GRAY_EN
  ,
  output logic [ADDR_W:0]   ptr_gray
`endif
);

  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_PTR  = ADDR_W'(DEPTH - 1);

  // Geometry sanity: the decoder needs every row addressable.
  if (DEPTH < 2 || DEPTH > (1 << ADDR_W)) begin : g_bad_depth
    $error("fifo_wr_sel: DEPTH must be in 2..2**ADDR_W");
  end

  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              wrap_q, wrap_d;
  logic              en_q, en_d;
  logic              load_err_q, load_err_d;

  // Next-state: load wins over advance; a rejected load freezes the pointer for the cycle.
  always_comb begin
    ptr_d      = ptr_q;
    wrap_d     = wrap_q;
    en_d       = en;
    load_err_d = 1'b0;
    if (load) begin
      if ({1'b0, load_addr} < DEPTH_EXT) begin
        ptr_d  = load_addr;
        wrap_d = 1'b0;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (advance) begin
      if (ptr_q == LAST_PTR) begin
        ptr_d  = '0;
        wrap_d = ~wrap_q;
      end else begin
        ptr_d  = ptr_q + ADDR_W'(1);
      end
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= '0;
      wrap_q     <= 1'b0;
      en_q       <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      wrap_q     <= wrap_d;
      en_q       <= en_d;
      load_err_q <= load_err_d;
    end
  end

  // Row select is decoded from registered state only, so no input reaches sel combinationally.
  onehot_dec #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_dec (
    .addr   (ptr_q),
    .en     (en_q),
    .onehot (sel)
  );

  assign ptr      = ptr_q;
  assign wrap     = wrap_q;
  assign load_err = load_err_q;

`ifdef FIFO_WR_SEL_GRAY_EN
  // Single-bit-change Gray steps only hold when the pointer uses the full binary range.
  if (DEPTH != (1 << ADDR_W)) begin : g_bad_gray
    $error("fifo_wr_sel: Gray pointer needs DEPTH == 2**ADDR_W");
  end

  logic [ADDR_W:0] gray_q, gray_d;

  // Gray code of the lap-extended pointer, computed from next state so it moves with ptr.
  always_comb begin
    gray_d = (ADDR_W+1)'(bin2gray(32'({wrap_d, ptr_d})));
  end

  // Gray register, cleared with the rest of the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gray_q <= '0;
    end else begin
      gray_q <= gray_d;
    end
  end

  assign ptr_gray = gray_q;
`endif

endmodule

// File: tb/tb_fifo_wr_sel.sv
// Directed bench for fifo_wr_sel: reset, advance/wrap, load priority and range error, en gating.
// Latency: outputs checked 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_fifo_wr_sel;
  import fifo_pkg::*;

  localparam int ADDR_W = 3;
`ifdef FIFO_WR_SEL_GRAY_EN
  localparam int DEPTH = 8;
`else
  localparam int DEPTH = 6;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              en;
  logic              advance;
  logic              load;
  logic [ADDR_W-1:0] load_addr;
  logic [DEPTH-1:0]  sel;
  logic [ADDR_W-1:0] ptr;
  logic              wrap;
  logic              load_err;
`ifdef FIFO_WR_SEL_GRAY_EN
  logic [ADDR_W:0]   ptr_gray;
`endif

  int vectors = 0;
  int errors  = 0;

  fifo_wr_sel #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .advance   (advance),
    .load      (load),
    .load_addr (load_addr),
    .sel       (sel),
    .ptr       (ptr),
    .wrap      (wrap),
    .load_err  (load_err)
`ifdef FIFO_WR_SEL_GRAY_EN
    ,
    .ptr_gray  (ptr_gray)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; advance = 1'b0; load = 1'b0; load_addr = '0;
    #12;
    vectors++;
    if (sel !== '0) begin errors++; $display("FAIL reset_sel: got %b want 0", sel); end
    vectors++;
    if (ptr !== '0) begin errors++; $display("FAIL reset_ptr: got %0d want 0", ptr); end
    vectors++;
    if (wrap !== 1'b0 || load_err !== 1'b0) begin
      errors++; $display("FAIL reset_flags: got wrap=%b err=%b want 0 0", wrap, load_err);
    end
    #5 rst_n = 1'b1;
    en = 1'b1;
    step();
    vectors++;
    if (sel !== DEPTH'(1)) begin errors++; $display("FAIL first_en_sel: got %b want %b", sel, DEPTH'(1)); end
    vectors++;
    if (ptr !== '0 || wrap !== 1'b0) begin
      errors++; $display("FAIL first_en_ptr: got ptr=%0d wrap=%b want 0 0", ptr, wrap);
    end
  endtask

`ifndef FIFO_WR_SEL_GRAY_EN
  task automatic test_advance_wrap();
    int exp_ptr [7] = '{1, 2, 3, 4, 5, 0, 1};
    bit exp_wrap[7] = '{0, 0, 0, 0, 0, 1, 1};
    logic [5:0] exp_sel [7] = '{6'b000010, 6'b000100, 6'b001000, 6'b010000,
                                6'b100000, 6'b000001, 6'b000010};
    en = 1'b1; advance = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      vectors++;
      if (ptr !== ADDR_W'(exp_ptr[i]) || wrap !== exp_wrap[i]) begin
        errors++;
        $display("FAIL adv_ptr step %0d: got ptr=%0d wrap=%b want ptr=%0d wrap=%b",
                 i, ptr, wrap, exp_ptr[i], exp_wrap[i]);
      end
      vectors++;
      if (sel !== exp_sel[i] || !is_onehot0(64'(sel))) begin
        errors++; $display("FAIL adv_sel step %0d: got %b want %b", i, sel, exp_sel[i]);
      end
    end
    advance = 1'b0;
  endtask

  // Starts at ptr=1, wrap=1: rejected loads must keep both.
  task automatic test_load_err();
    load = 1'b1; load_addr = 3'd7; advance = 1'b1;
    step();
    load = 1'b0; advance = 1'b0;
    vectors++;
    if (load_err !== 1'b1) begin errors++; $display("FAIL err7_pulse: got %b want 1", load_err); end
    vectors++;
    if (ptr !== 3'd1 || wrap !== 1'b1) begin
      errors++; $display("FAIL err7_hold: got ptr=%0d wrap=%b want 1 1", ptr, wrap);
    end
    step();
    vectors++;
    if (load_err !== 1'b0 || ptr !== 3'd1) begin
      errors++; $display("FAIL err7_clear: got err=%b ptr=%0d want 0 1", load_err, ptr);
    end
    load = 1'b1; load_addr = 3'd6;
    step();
    load = 1'b0;
    vectors++;
    if (load_err !== 1'b1 || ptr !== 3'd1 || wrap !== 1'b1) begin
      errors++; $display("FAIL err6_edge: got err=%b ptr=%0d wrap=%b want 1 1 1", load_err, ptr, wrap);
    end
    step();
    vectors++;
    if (load_err !== 1'b0) begin errors++; $display("FAIL err6_clear: got %b want 0", load_err); end
  endtask

  task automatic test_load_priority();
    load = 1'b1; load_addr = 3'd4; advance = 1'b1;
    step();
    load = 1'b0; advance = 1'b0;
    vectors++;
    if (ptr !== 3'd4 || wrap !== 1'b0) begin
      errors++; $display("FAIL load_prio_ptr: got ptr=%0d wrap=%b want 4 0", ptr, wrap);
    end
    vectors++;
    if (sel !== 6'b010000 || load_err !== 1'b0) begin
      errors++; $display("FAIL load_prio_sel: got sel=%b err=%b want 010000 0", sel, load_err);
    end
  endtask

  task automatic test_en_gate();
    en = 1'b0; load = 1'b1; load_addr = 3'd2;
    step();
    load = 1'b0;
    vectors++;
    if (ptr !== 3'd2 || sel !== '0) begin
      errors++; $display("FAIL gate_load: got ptr=%0d sel=%b want 2 0", ptr, sel);
    end
    advance = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (sel !== '0 || ptr !== ADDR_W'(3 + i)) begin
        errors++; $display("FAIL gate_adv step %0d: got ptr=%0d sel=%b want %0d 0", i, ptr, sel, 3 + i);
      end
    end
    advance = 1'b0; en = 1'b1;
    #1;
    vectors++;
    if (sel !== '0) begin errors++; $display("FAIL gate_comb: got %b want 0", sel); end
    step();
    vectors++;
    if (sel !== 6'b100000 || ptr !== 3'd5) begin
      errors++; $display("FAIL gate_reen: got sel=%b ptr=%0d want 100000 5", sel, ptr);
    end
  endtask

  task automatic test_reset_mid();
    advance = 1'b1;
    step();
    vectors++;
    if (ptr !== 3'd0 || wrap !== 1'b1) begin
      errors++; $display("FAIL mid_pre: got ptr=%0d wrap=%b want 0 1", ptr, wrap);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (sel !== '0 || ptr !== '0 || wrap !== 1'b0 || load_err !== 1'b0) begin
      errors++; $display("FAIL mid_async: got sel=%b ptr=%0d wrap=%b err=%b want all 0", sel, ptr, wrap, load_err);
    end
    advance = 1'b0;
    #3 rst_n = 1'b1;
    step();
    vectors++;
    if (sel !== 6'b000001 || ptr !== 3'd0) begin
      errors++; $display("FAIL mid_resume: got sel=%b ptr=%0d want 000001 0", sel, ptr);
    end
  endtask
`else
  task automatic test_gray();
    logic [ADDR_W:0] prev;
    logic [ADDR_W:0] exp_g;
    int k;
    prev = ptr_gray;
    vectors++;
    if (prev !== '0) begin errors++; $display("FAIL gray_start: got %b want 0", prev); end
    en = 1'b1; advance = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      k = (i + 1) % 16;
      exp_g = 4'(k ^ (k >> 1));
      vectors++;
      if (ptr_gray !== exp_g || $countones(ptr_gray ^ prev) != 1) begin
        errors++; $display("FAIL gray_step %0d: got %b prev %b want %b", i, ptr_gray, prev, exp_g);
      end
      vectors++;
      if (sel !== DEPTH'(1 << (k % 8))) begin
        errors++; $display("FAIL gray_sel %0d: got %b want %b", i, sel, DEPTH'(1 << (k % 8)));
      end
      prev = ptr_gray;
    end
    vectors++;
    if (ptr_gray !== '0 || wrap !== 1'b0) begin
      errors++; $display("FAIL gray_return: got %b wrap=%b want 0 0", ptr_gray, wrap);
    end
    step(); step(); step();
    vectors++;
    if (ptr_gray !== 4'b0010) begin errors++; $display("FAIL gray_mid_pre: got %b want 0010", ptr_gray); end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (ptr_gray !== '0 || sel !== '0 || ptr !== '0 || wrap !== 1'b0 || load_err !== 1'b0) begin
      errors++; $display("FAIL gray_mid_async: got gray=%b sel=%b ptr=%0d wrap=%b err=%b want all 0",
                         ptr_gray, sel, ptr, wrap, load_err);
    end
    #3 rst_n = 1'b1;
    advance = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
`ifndef FIFO_WR_SEL_GRAY_EN
    test_advance_wrap();
    test_load_err();
    test_load_priority();
    test_en_gate();
    test_reset_mid();
`else
    test_gray();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
